// File: rtl/gb_sound_pkg.sv
// gb_sound_pkg: register offsets, read masks and field positions shared by the
// sound channel register front ends.
`default_nettype none

package gb_sound_pkg;

   // Offsets from the channel base address.
   localparam logic [1:0] NR41_OFF = 2'd0;
   localparam logic [1:0] NR42_OFF = 2'd1;
   localparam logic [1:0] NR43_OFF = 2'd2;
   localparam logic [1:0] NR44_OFF = 2'd3;

   // Bits that always read back as 1.
   localparam logic [7:0] NR41_RD_MASK = 8'hFF;
   localparam logic [7:0] NR44_RD_MASK = 8'hBF;

   localparam int NR42_DIR_BIT    = 3;
   localparam int NR43_WIDTH_BIT  = 3;
   localparam int NR44_LEN_EN_BIT = 6;
   localparam int NR44_TRIG_BIT   = 7;

   function automatic logic [7:0] nr44_readback(input logic len_en);
      logic [7:0] val;
      val = NR44_RD_MASK;
      val[NR44_LEN_EN_BIT] = len_en;
      return val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/noise_reg_if.sv
// noise_reg_if: CPU register front end for the noise channel (NR41..NR44).
// Holds parameter fields as levels and generates trigger / length-load strobes.
`default_nettype none

module noise_reg_if
   import gb_sound_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'h20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       power_on,
   input  logic [7:0] addr,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic [5:0] length_load,
   output logic       length_strobe,
   output logic [3:0] env_init_vol,
   output logic       env_dir,
   output logic [2:0] env_period,
   output logic [3:0] clock_shift,
   output logic       width_mode,
   output logic [2:0] divisor_code,
   output logic       length_enable,
   output logic       trigger,
   output logic       dac_enable
);

   logic [7:0] w_off;
   logic       w_hit;
   logic [1:0] w_reg;
   logic       w_wr;
   logic       w_rd;
   logic [7:0] w_rd_mux;

   logic [5:0] r_nr41_len;
   logic [7:0] r_nr42;
   logic [7:0] r_nr43;
   logic       r_len_en;
   logic       r_trigger;
   logic       r_len_strobe;
   logic [7:0] r_rd_data;
   logic       r_rd_valid;

   // Modular offset keeps the range check correct even if the base sits near 8'hFF.
   assign w_off = addr - BASE_ADDR;
   assign w_hit = (w_off[7:2] == 6'd0);
   assign w_reg = w_off[1:0];
   assign w_wr  = wr_en & power_on & w_hit;
   assign w_rd  = rd_en & w_hit;

   always_comb begin
      w_rd_mux = NR41_RD_MASK;
      case (w_reg)
         NR41_OFF: w_rd_mux = NR41_RD_MASK;
         NR42_OFF: w_rd_mux = r_nr42;
         NR43_OFF: w_rd_mux = r_nr43;
         NR44_OFF: w_rd_mux = nr44_readback(r_len_en);
         default:  w_rd_mux = NR41_RD_MASK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || !power_on) begin
         r_nr41_len <= 6'd0;
         r_nr42     <= 8'd0;
         r_nr43     <= 8'd0;
         r_len_en   <= 1'b0;
      end else if (w_wr) begin
         case (w_reg)
            NR41_OFF: r_nr41_len <= wr_data[5:0];
            NR42_OFF: r_nr42     <= wr_data;
            NR43_OFF: r_nr43     <= wr_data;
            NR44_OFF: r_len_en   <= wr_data[NR44_LEN_EN_BIT];
            default:  r_nr42     <= r_nr42;
         endcase
      end
   end

   // Strobes are single-cycle by construction: recomputed from this cycle's write only.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len_strobe <= 1'b0;
         r_trigger    <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_rd_data    <= 8'hFF;
      end else begin
         r_len_strobe <= w_wr && (w_reg == NR41_OFF);
         r_trigger    <= w_wr && (w_reg == NR44_OFF) && wr_data[NR44_TRIG_BIT];
         r_rd_valid   <= w_rd;
         if (w_rd) begin
            r_rd_data <= w_rd_mux;
         end
      end
   end

   assign rd_data       = r_rd_data;
   assign rd_valid      = r_rd_valid;
   assign length_load   = r_nr41_len;
   assign length_strobe = r_len_strobe;
   assign env_init_vol  = r_nr42[7:4];
   assign env_dir       = r_nr42[NR42_DIR_BIT];
   assign env_period    = r_nr42[2:0];
   assign clock_shift   = r_nr43[7:4];
   assign width_mode    = r_nr43[NR43_WIDTH_BIT];
   assign divisor_code  = r_nr43[2:0];
   assign length_enable = r_len_en;
   assign trigger       = r_trigger;
   assign dac_enable    = |r_nr42[7:3];

endmodule

`default_nettype wire

// File: tb/tb_noise_reg_if.sv
// tb_noise_reg_if: directed scenarios plus randomized traffic checked against a
// register-map model of the noise channel front end.
`default_nettype none

module tb_noise_reg_if;

   localparam logic [7:0] BASE = 8'h20;

   logic       clk;
   logic       reset;
   logic       power_on;
   logic [7:0] addr;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [5:0] length_load;
   logic       length_strobe;
   logic [3:0] env_init_vol;
   logic       env_dir;
   logic [2:0] env_period;
   logic [3:0] clock_shift;
   logic       width_mode;
   logic [2:0] divisor_code;
   logic       length_enable;
   logic       trigger;
   logic       dac_enable;

   int n_checks = 0;
   int n_errors = 0;

   // Model: register contents as the CPU sees them, plus last cycle's strobes/read.
   logic [5:0] m_len;
   logic [7:0] m_nr42;
   logic [7:0] m_nr43;
   logic       m_len_en;
   logic       m_trig;
   logic       m_lstb;
   logic [7:0] m_rdd;
   logic       m_rdv;

   noise_reg_if #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .power_on(power_on), .addr(addr),
      .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
      .rd_valid(rd_valid), .length_load(length_load), .length_strobe(length_strobe),
      .env_init_vol(env_init_vol), .env_dir(env_dir), .env_period(env_period),
      .clock_shift(clock_shift), .width_mode(width_mode), .divisor_code(divisor_code),
      .length_enable(length_enable), .trigger(trigger), .dac_enable(dac_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One bus cycle: apply inputs, advance the model, sample 1 time unit after the edge.
   task automatic drive(input logic [7:0] a, input logic we, input logic [7:0] wd,
                        input logic re, input logic pw);
      logic [7:0] d;
      int         idx;
      logic       hit;
      addr = a; wr_en = we; wr_data = wd; rd_en = re; power_on = pw;
      d   = a - BASE;
      hit = (d < 8'd4);
      idx = int'(d);
      if (reset) begin
         m_len = 0; m_nr42 = 0; m_nr43 = 0; m_len_en = 0;
         m_trig = 0; m_lstb = 0; m_rdv = 0; m_rdd = 8'hFF;
      end else begin
         m_rdv = re && hit;
         if (re && hit) begin
            if (idx == 0)      m_rdd = 8'hFF;
            else if (idx == 1) m_rdd = m_nr42;
            else if (idx == 2) m_rdd = m_nr43;
            else               m_rdd = {1'b1, m_len_en, 6'h3F};
         end
         m_lstb = pw && we && hit && idx == 0;
         m_trig = pw && we && hit && idx == 3 && wd[7];
         if (!pw) begin
            m_len = 0; m_nr42 = 0; m_nr43 = 0; m_len_en = 0;
         end else if (we && hit) begin
            if (idx == 0)      m_len = wd[5:0];
            else if (idx == 1) m_nr42 = wd;
            else if (idx == 2) m_nr43 = wd;
            else               m_len_en = wd[6];
         end
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic idle(input logic pw);
      drive(8'h00, 1'b0, 8'h00, 1'b0, pw);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle(1'b1);
      idle(1'b1);
      reset = 1'b0;
      n_checks++;
      if ({rd_data, rd_valid, length_load, length_strobe, env_init_vol, env_dir, env_period,
           clock_shift, width_mode, divisor_code, length_enable, trigger, dac_enable}
          !== {8'hFF, 27'd0}) begin
         n_errors++;
         $display("FAIL reset_outputs: rd_data=%h strobes=%b%b%b dac=%b vol=%h (need FF, all zero)",
                  rd_data, rd_valid, length_strobe, trigger, dac_enable, env_init_vol);
      end
      for (int i = 0; i < 4; i++) begin
         logic [7:0] want;
         want = (i == 0) ? 8'hFF : (i == 3) ? 8'hBF : 8'h00;
         drive(BASE + 8'(i), 1'b0, 8'h00, 1'b1, 1'b1);
         n_checks++;
         if (rd_data !== want || rd_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_read[%0d]: got %h valid %b, expected %h valid 1", i, rd_data, rd_valid, want);
         end
      end
   endtask

   task automatic test_writes;
      drive(BASE + 8'd1, 1'b1, 8'h73, 1'b0, 1'b1);
      n_checks++;
      if (env_init_vol !== 4'd7 || env_dir !== 1'b0 || env_period !== 3'd3 || dac_enable !== 1'b1) begin
         n_errors++;
         $display("FAIL nr42_fields: vol=%h dir=%b per=%h dac=%b, expected 7 0 3 1",
                  env_init_vol, env_dir, env_period, dac_enable);
      end
      drive(BASE + 8'd2, 1'b1, 8'h00, 1'b0, 1'b1);
      drive(BASE, 1'b1, 8'h3F, 1'b0, 1'b1);
      n_checks++;
      if (length_load !== 6'd63 || length_strobe !== 1'b1) begin
         n_errors++;
         $display("FAIL nr41_write: len=%0d strobe=%b, expected 63 1", length_load, length_strobe);
      end
      drive(BASE + 8'd3, 1'b1, 8'h80, 1'b0, 1'b1);
      n_checks++;
      if (length_strobe !== 1'b0 || trigger !== 1'b1 || length_enable !== 1'b0) begin
         n_errors++;
         $display("FAIL nr44_trigger: lstb=%b trig=%b len_en=%b, expected 0 1 0",
                  length_strobe, trigger, length_enable);
      end
      idle(1'b1);
      n_checks++;
      if (trigger !== 1'b0) begin
         n_errors++;
         $display("FAIL trigger_single: trig=%b, expected 0", trigger);
      end
   endtask

   task automatic test_back_to_back;
      drive(BASE + 8'd3, 1'b1, 8'h40, 1'b0, 1'b1);
      n_checks++;
      if (length_enable !== 1'b1 || trigger !== 1'b0) begin
         n_errors++;
         $display("FAIL nr44_len_en: len_en=%b trig=%b, expected 1 0", length_enable, trigger);
      end
      drive(BASE + 8'd3, 1'b0, 8'h00, 1'b1, 1'b1);
      n_checks++;
      if (rd_data !== 8'hFF) begin
         n_errors++;
         $display("FAIL nr44_read: got %h, expected FF", rd_data);
      end
      drive(BASE + 8'd3, 1'b1, 8'hC0, 1'b0, 1'b1);
      n_checks++;
      if (trigger !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_trig1: trig=%b, expected 1", trigger);
      end
      drive(BASE + 8'd3, 1'b1, 8'hC0, 1'b0, 1'b1);
      n_checks++;
      if (trigger !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_trig2: trig=%b, expected 1", trigger);
      end
      drive(BASE, 1'b1, 8'hC5, 1'b0, 1'b1);
      n_checks++;
      if (trigger !== 1'b0 || length_strobe !== 1'b1 || length_load !== 6'h05) begin
         n_errors++;
         $display("FAIL nr41_then_44a: trig=%b lstb=%b len=%h, expected 0 1 05", trigger, length_strobe, length_load);
      end
      drive(BASE + 8'd3, 1'b1, 8'h80, 1'b0, 1'b1);
      n_checks++;
      if (trigger !== 1'b1 || length_strobe !== 1'b0 || length_enable !== 1'b0) begin
         n_errors++;
         $display("FAIL nr41_then_44b: trig=%b lstb=%b len_en=%b, expected 1 0 0", trigger, length_strobe, length_enable);
      end
   endtask

   task automatic test_same_cycle_rw;
      drive(BASE + 8'd2, 1'b1, 8'hA9, 1'b1, 1'b1);
      n_checks++;
      if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL rw_same_cycle: got %h valid %b, expected 00 1", rd_data, rd_valid);
      end
      drive(BASE + 8'd2, 1'b0, 8'h00, 1'b1, 1'b1);
      n_checks++;
      if (rd_data !== 8'hA9 || clock_shift !== 4'hA || width_mode !== 1'b1 || divisor_code !== 3'd1) begin
         n_errors++;
         $display("FAIL nr43_reread: rd=%h shift=%h wm=%b div=%0d, expected A9 A 1 1",
                  rd_data, clock_shift, width_mode, divisor_code);
      end
   endtask

   task automatic test_power;
      drive(BASE + 8'd1, 1'b1, 8'hF3, 1'b0, 1'b1);
      drive(BASE + 8'd3, 1'b1, 8'h40, 1'b0, 1'b1);
      idle(1'b0);
      n_checks++;
      if ({length_load, env_init_vol, env_dir, env_period, clock_shift, width_mode,
           divisor_code, length_enable, dac_enable} !== 27'd0) begin
         n_errors++;
         $display("FAIL power_clear: vol=%h shift=%h len=%h len_en=%b dac=%b, expected all 0",
                  env_init_vol, clock_shift, length_load, length_enable, dac_enable);
      end
      drive(BASE + 8'd3, 1'b1, 8'h80, 1'b0, 1'b0);
      n_checks++;
      if (trigger !== 1'b0) begin
         n_errors++;
         $display("FAIL power_no_trig: trig=%b, expected 0", trigger);
      end
      drive(BASE + 8'd1, 1'b1, 8'hF0, 1'b0, 1'b0);
      drive(BASE + 8'd1, 1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (rd_data !== 8'h00 || dac_enable !== 1'b0) begin
         n_errors++;
         $display("FAIL power_nr42_read: got %h dac %b, expected 00 0", rd_data, dac_enable);
      end
      drive(BASE + 8'd3, 1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (rd_data !== 8'hBF) begin
         n_errors++;
         $display("FAIL power_nr44_read: got %h, expected BF", rd_data);
      end
      idle(1'b1);
      idle(1'b1);
      n_checks++;
      if (env_init_vol !== 4'd0 || length_enable !== 1'b0) begin
         n_errors++;
         $display("FAIL power_rise: vol=%h len_en=%b, expected 0 0", env_init_vol, length_enable);
      end
   endtask

   task automatic test_out_of_range;
      drive(BASE + 8'd1, 1'b1, 8'h55, 1'b0, 1'b1);
      drive(BASE + 8'd1, 1'b0, 8'h00, 1'b1, 1'b1);
      drive(BASE + 8'd4, 1'b1, 8'hFF, 1'b1, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== 8'h55 || env_init_vol !== 4'h5 || env_period !== 3'd5
          || length_strobe !== 1'b0 || trigger !== 1'b0) begin
         n_errors++;
         $display("FAIL out_of_range_hi: valid=%b rd=%h vol=%h per=%h, expected 0 55 5 5",
                  rd_valid, rd_data, env_init_vol, env_period);
      end
      drive(BASE - 8'd1, 1'b1, 8'hFF, 1'b1, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== 8'h55 || env_init_vol !== 4'h5 || trigger !== 1'b0) begin
         n_errors++;
         $display("FAIL out_of_range_lo: valid=%b rd=%h vol=%h trig=%b, expected 0 55 5 0",
                  rd_valid, rd_data, env_init_vol, trigger);
      end
   endtask

   task automatic test_reset_mid;
      drive(BASE, 1'b1, 8'h2A, 1'b0, 1'b1);
      n_checks++;
      if (length_strobe !== 1'b1 || length_load !== 6'h2A) begin
         n_errors++;
         $display("FAIL mid_pre_strobe: lstb=%b len=%h, expected 1 2A", length_strobe, length_load);
      end
      reset = 1'b1;
      idle(1'b1);
      reset = 1'b0;
      n_checks++;
      if (length_strobe !== 1'b0 || length_load !== 6'd0 || env_init_vol !== 4'd0 || rd_data !== 8'hFF) begin
         n_errors++;
         $display("FAIL mid_reset: lstb=%b len=%h vol=%h rd=%h, expected 0 00 0 FF",
                  length_strobe, length_load, env_init_vol, rd_data);
      end
   endtask

   task automatic test_random;
      logic [34:0] got;
      logic [34:0] exp;
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive(BASE - 8'd2 + 8'($urandom_range(0, 7)), 1'($urandom), 8'($urandom),
               1'($urandom), ($urandom_range(0, 9) != 0));
         reset = 1'b0;
         got = {rd_data, rd_valid, length_load, length_strobe, env_init_vol, env_dir, env_period,
                clock_shift, width_mode, divisor_code, length_enable, trigger, dac_enable};
         exp = {m_rdd, m_rdv, m_len, m_lstb, m_nr42[7:4], m_nr42[3], m_nr42[2:0],
                m_nr43[7:4], m_nr43[3], m_nr43[2:0], m_len_en, m_trig, |m_nr42[7:3]};
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL random[%0d]: outputs %h, expected %h", n, got, exp);
         end
      end
   endtask

   initial begin
      reset = 1'b1; power_on = 1'b1; addr = 8'h00; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
      test_reset();
      test_writes();
      test_back_to_back();
      test_same_cycle_rw();
      test_power();
      test_out_of_range();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/noise_reg_if.md
Name: noise_reg_if

Overview:
- CPU-side register front end for the noise channel: decodes byte writes/reads to NR41–NR44.
- Holds the channel's parameter fields and drives them as levels into noiseChannel.
- Generates the one-cycle trigger and length-load strobes.
- Sits between the bus/register decoder and noiseChannel; it is the writer for the parameter interface that noiseChannel reads.

Parameters:
- BASE_ADDR, 8'h20, low address byte of NR41; NR42..NR44 occupy BASE_ADDR+1..+3.

Ports:
- clk  in  1  system clock (4 MHz base clock)
- reset  in  1  synchronous, active-high reset
- power_on  in  1  NR52 master enable; low = registers held cleared, writes ignored
- addr  in  8  low address byte
- wr_en  in  1  write strobe, one cycle per write
- wr_data  in  8  write data
- rd_en  in  1  read strobe
- rd_data  out  8  read data, registered
- rd_valid  out  1  high one cycle after an rd_en that hits the block
- length_load  out  6  NR41[5:0]
- length_strobe  out  1  one-cycle pulse after an NR41 write
- env_init_vol  out  4  NR42[7:4]
- env_dir  out  1  NR42[3], 1 = increase
- env_period  out  3  NR42[2:0]
- clock_shift  out  4  NR43[7:4]
- width_mode  out  1  NR43[3], 1 = 7-bit LFSR
- divisor_code  out  3  NR43[2:0]
- length_enable  out  1  NR44[6]
- trigger  out  1  one-cycle pulse after an NR44 write with bit7 = 1
- dac_enable  out  1  combinational: |NR42[7:3]

Behaviour:
- Reset: all fields 0; trigger, length_strobe, rd_valid = 0; rd_data = 8'hFF. dac_enable follows to 0.
- Write, with power_on = 1 and wr_en = 1: the matching register updates at the next clk edge.
- Outputs reflect the written value in the cycle after the write (1-cycle latency).
- NR41 write: store bits[5:0] and assert length_strobe for exactly one cycle; bits[7:6] are ignored.
- NR42 and NR43 writes: store the full byte.
- NR44 write: store bit6 into length_enable.
  - If bit7 = 1, trigger = 1 for exactly one cycle, concurrent with the new length_enable.
  - Bits[5:0] are ignored.
- Back-to-back NR44 writes with bit7 set give trigger high on consecutive cycles; no merging, no suppression.
- An NR41 and NR44 write cannot coincide (single bus). A trigger one cycle after an NR41 write is passed through unchanged.
- Address outside BASE_ADDR..+3: no state change, no strobe, rd_valid = 0.
- Read, registered with 1-cycle latency:
  - NR41 → 8'hFF (write-only).
  - NR42 → stored byte.
  - NR43 → stored byte.
  - NR44 → {1'b1, length_enable, 6'h3F}.
- rd_data holds its last value when there is no read.
- Read and write to the same register in the same cycle: rd_data returns the pre-write value.
- power_on low:
  - All fields clear synchronously.
  - Writes are ignored; no strobes are generated.
  - Reads still respond using the cleared values, e.g. NR44 → 8'hBF.
- power_on rising: fields stay 0 until written.
- Reset mid-operation: a strobe already asserted in the current cycle is dropped next cycle, and all fields return to 0.
- trigger is pulsed even when dac_enable = 0; noiseChannel decides whether the channel starts.

Decomposition:
- Shared package (gb_sound_pkg):
  - Register offset constants NR41_OFF..NR44_OFF.
  - Read-mask constants: NR41 8'hFF, NR44 8'hBF.
  - Field bit-position constants.
- No sub-module. A generic one-cycle pulse register could be factored later as sound_strobe if the square and wave channels need the same front end.

Test Plan:
- Reset, then read all four registers → FF, 00, 00, BF; all outputs 0; dac_enable 0.
- Write NR42 = 8'h73, NR43 = 8'h00, NR41 = 8'h3F, NR44 = 8'h80 →
  - env_init_vol 7, env_dir 0, env_period 3, dac_enable 1.
  - length_load 63, length_strobe one cycle.
  - trigger exactly one cycle, length_enable 0 (matches the existing noise-channel stimulus).
- Write NR44 = 8'h40 → length_enable 1, no trigger; read NR44 → 8'hFF. Write NR44 = 8'hC0 twice back-to-back → trigger high on two consecutive cycles.
- Write NR43 = 8'hA9 and read NR43 in the same cycle → rd_data old value 00 next cycle. Re-read → A9; clock_shift A, width_mode 1, divisor_code 1.
- Drop power_on → all fields 0 next cycle. Write NR44 = 8'h80 → no trigger. Write NR42 = 8'hF0 → read back 00.
- Write to addr BASE_ADDR+4 → no field change, rd_valid stays 0. Assert reset during a length_strobe cycle → strobe low next cycle, fields 0.
